// File: rtl/exec_sched_pkg.sv
// Shared encodings for the execution-unit issue scheduler: decoder
// ALUSelect values, writeback mux selects and the scheduler states.
package exec_sched_pkg;

    localparam logic [1:0] SEL_NONE   = 2'b00;
    localparam logic [1:0] SEL_IALU   = 2'b01;
    localparam logic [1:0] SEL_FALU   = 2'b10;
    localparam logic [1:0] SEL_CORDIC = 2'b11;

    typedef enum logic [1:0] {
        WB_IALU   = 2'b00,
        WB_LSU    = 2'b01,
        WB_FALU   = 2'b10,
        WB_CORDIC = 2'b11
    } wb_src_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } sched_state_e;

    // Width of a counter that must hold 0..t; a disabled (t=0) timeout
    // still gets a one-bit counter so no zero-width vector is declared.
    function automatic int unsigned cnt_width(input int unsigned t);
        if (t > 32'd0) begin
            return $clog2(t + 32'd1);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/sched_timeout_cnt.sv
// Watchdog counter for the WAIT state. Held at zero while clear is high,
// counts cycles while enable is high, and flags the last allowed cycle
// (count == TIMEOUT-1). TIMEOUT=0 never expires.
module sched_timeout_cnt
    import exec_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned    CW    = cnt_width(TIMEOUT);
    localparam logic [CW-1:0]  LIMIT = (TIMEOUT > 32'd0) ? CW'(TIMEOUT - 32'd1) : {CW{1'b0}};

    logic [CW-1:0] cnt_r;

    // Cycle counter: cleared outside WAIT, stops once the limit is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (enable && !expired) begin
            cnt_r <= cnt_r + CW'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign expired = 1'b0;
        end else begin : g_timeout
            assign expired = enable && (cnt_r == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/exec_issue_sched.sv
// In-order issue scheduler. Accepts one decoded instruction per handshake,
// starts the selected multi-cycle unit (LSU/FALU/CORDIC) and stalls the
// decoder until that unit reports done, or writes IALU results straight
// through. Owns the single register-file write port and reports illegal
// selects and unit timeouts.
module exec_issue_sched
    import exec_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT         = 64,
    parameter int unsigned ALUSELECT_WIDTH = 2,
    parameter int unsigned RADDR_WIDTH     = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       dec_valid,
    output logic                       dec_ready,
    input  logic [ALUSELECT_WIDTH-1:0] dec_alusel,
    input  logic                       dec_rwe,
    input  logic                       dec_load,
    input  logic                       dec_mwe,
    input  logic [RADDR_WIDTH-1:0]     dec_rd,
    output logic                       falu_start,
    input  logic                       falu_done,
    output logic                       cordic_start,
    input  logic                       cordic_done,
    output logic                       lsu_start,
    input  logic                       lsu_done,
    output logic                       wb_we,
    output logic [RADDR_WIDTH:0]       wb_addr,
    output logic [1:0]                 wb_src,
    output logic                       busy,
    output logic                       illegal,
    output logic                       timeout_err
);

    sched_state_e           state_r, state_nx_s;
    wb_src_e                unit_r, unit_nx_s;
    logic                   rwe_r, rwe_nx_s;
    logic [RADDR_WIDTH:0]   addr_r, addr_nx_s;

    logic                   wb_we_r, wb_we_nx_s;
    logic [RADDR_WIDTH:0]   wb_addr_r, wb_addr_nx_s;
    wb_src_e                wb_src_r, wb_src_nx_s;
    logic                   illegal_r, illegal_nx_s;
    logic                   timeout_err_r, timeout_err_nx_s;

    logic                   accept_s;
    logic                   mem_op_s;
    logic                   done_s;
    logic                   expired_s;
    logic [RADDR_WIDTH:0]   addr_in_s;
    logic                   falu_start_s, cordic_start_s, lsu_start_s;

    assign addr_in_s = {dec_alusel[ALUSELECT_WIDTH-1], dec_rd};

    // Handshake and start strobes; loads/stores take priority over ALUSelect.
    always_comb begin
        accept_s       = dec_valid && (state_r == S_IDLE);
        mem_op_s       = dec_load || dec_mwe;
        falu_start_s   = 1'b0;
        cordic_start_s = 1'b0;
        lsu_start_s    = 1'b0;
        if (accept_s) begin
            if (mem_op_s) begin
                lsu_start_s = 1'b1;
            end else if (dec_alusel == SEL_FALU) begin
                falu_start_s = 1'b1;
            end else if (dec_alusel == SEL_CORDIC) begin
                cordic_start_s = 1'b1;
            end else begin
                lsu_start_s = 1'b0;
            end
        end else begin
            lsu_start_s = 1'b0;
        end
    end

    // Only the unit that was started may end the wait.
    always_comb begin
        done_s = 1'b0;
        case (unit_r)
            WB_LSU:    done_s = lsu_done;
            WB_FALU:   done_s = falu_done;
            WB_CORDIC: done_s = cordic_done;
            default:   done_s = 1'b0;
        endcase
    end

    sched_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_r == S_IDLE),
        .enable  (state_r == S_WAIT),
        .expired (expired_s)
    );

    // Next state, latched operation context and next registered outputs.
    always_comb begin
        state_nx_s       = state_r;
        unit_nx_s        = unit_r;
        rwe_nx_s         = rwe_r;
        addr_nx_s        = addr_r;
        wb_we_nx_s       = 1'b0;
        wb_addr_nx_s     = wb_addr_r;
        wb_src_nx_s      = wb_src_r;
        illegal_nx_s     = 1'b0;
        timeout_err_nx_s = timeout_err_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (mem_op_s) begin
                        state_nx_s = S_WAIT;
                        unit_nx_s  = WB_LSU;
                        rwe_nx_s   = dec_rwe && dec_load;
                        addr_nx_s  = addr_in_s;
                    end else begin
                        case (dec_alusel)
                            SEL_FALU: begin
                                state_nx_s = S_WAIT;
                                unit_nx_s  = WB_FALU;
                                rwe_nx_s   = dec_rwe;
                                addr_nx_s  = addr_in_s;
                            end
                            SEL_CORDIC: begin
                                state_nx_s = S_WAIT;
                                unit_nx_s  = WB_CORDIC;
                                rwe_nx_s   = dec_rwe;
                                addr_nx_s  = addr_in_s;
                            end
                            SEL_IALU: begin
                                wb_we_nx_s   = dec_rwe;
                                wb_addr_nx_s = addr_in_s;
                                wb_src_nx_s  = WB_IALU;
                            end
                            default: begin
                                illegal_nx_s = 1'b1;
                                wb_addr_nx_s = addr_in_s;
                                wb_src_nx_s  = WB_IALU;
                            end
                        endcase
                    end
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_WAIT: begin
                // A done arriving on the last allowed cycle still completes.
                if (done_s) begin
                    state_nx_s   = S_IDLE;
                    wb_we_nx_s   = rwe_r;
                    wb_addr_nx_s = addr_r;
                    wb_src_nx_s  = unit_r;
                end else if (expired_s) begin
                    state_nx_s       = S_IDLE;
                    timeout_err_nx_s = 1'b1;
                end else begin
                    state_nx_s = S_WAIT;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // State, operation context and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            unit_r        <= WB_IALU;
            rwe_r         <= 1'b0;
            addr_r        <= {(RADDR_WIDTH+1){1'b0}};
            wb_we_r       <= 1'b0;
            wb_addr_r     <= {(RADDR_WIDTH+1){1'b0}};
            wb_src_r      <= WB_IALU;
            illegal_r     <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            unit_r        <= unit_nx_s;
            rwe_r         <= rwe_nx_s;
            addr_r        <= addr_nx_s;
            wb_we_r       <= wb_we_nx_s;
            wb_addr_r     <= wb_addr_nx_s;
            wb_src_r      <= wb_src_nx_s;
            illegal_r     <= illegal_nx_s;
            timeout_err_r <= timeout_err_nx_s;
        end
    end

    assign dec_ready    = (state_r == S_IDLE);
    assign busy         = (state_r == S_WAIT);
    assign falu_start   = falu_start_s;
    assign cordic_start = cordic_start_s;
    assign lsu_start    = lsu_start_s;
    assign wb_we        = wb_we_r;
    assign wb_addr      = wb_addr_r;
    assign wb_src       = wb_src_r;
    assign illegal      = illegal_r;
    assign timeout_err  = timeout_err_r;

endmodule

// File: doc/exec_issue_sched.md
Name: exec_issue_sched

Overview:
- In-order issue scheduler between the instruction decoder and the execution units (IALU, FALU, CORDIC, LSU).
- Accepts one decoded instruction per handshake and routes it by ALUSelect/load/MWE.
- Pulses the start strobe of the selected multi-cycle unit and stalls the decoder until that unit reports done.
- Drives the single register-file write port (write enable, 6-bit extended address, writeback source select) and flags illegal selects and unit timeouts.

Parameters:
TIMEOUT, 64, max cycles in WAIT before abort; 0 disables the timeout
ALUSELECT_WIDTH, 2, width of decoder ALUSelect field
RADDR_WIDTH, 5, architectural register index width (write address is RADDR_WIDTH+1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
dec_valid  in  1  decoded instruction present
dec_ready  out  1  scheduler accepts instruction this cycle
dec_alusel  in  2  ALUSelect from decoder (01 IALU, 10 FALU, 11 CORDIC, 00 illegal)
dec_rwe  in  1  register write enable from decoder
dec_load  in  1  load instruction
dec_mwe  in  1  store instruction
dec_rd  in  5  destination register index
falu_start  out  1  one-cycle start pulse to FALU
falu_done  in  1  FALU result valid
cordic_start  out  1  one-cycle start pulse to CORDIC
cordic_done  in  1  CORDIC result valid
lsu_start  out  1  one-cycle start pulse to LSU
lsu_done  in  1  LSU access complete
wb_we  out  1  register-file write enable (registered)
wb_addr  out  6  {dec_alusel[1], dec_rd}, latched at accept
wb_src  out  2  writeback mux select: 00 IALU, 01 LSU, 10 FALU, 11 CORDIC
busy  out  1  high while in WAIT
illegal  out  1  one-cycle pulse on accepted ALUSelect=00
timeout_err  out  1  sticky flag; cleared only by reset

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - Outputs zero: wb_we, wb_addr, wb_src, busy, illegal, timeout_err, all *_start.
  - dec_ready=1 as soon as reset releases.
- States: IDLE, WAIT. In IDLE, dec_ready=1; in WAIT, dec_ready=0. Accept = dec_valid & dec_ready.
- Accept in IDLE, cycle T. Priority is load/store > alusel:
  - dec_load|dec_mwe: lsu_start=1 combinationally in T; latch unit=LSU, wb_src=01, rwe=dec_rwe&dec_load, addr; go WAIT at T+1.
  - alusel=10 or 11: falu_start or cordic_start=1 in T; latch unit, wb_src, rwe, addr; go WAIT.
  - alusel=01: no start; at T+1 wb_we=dec_rwe, wb_src=00, wb_addr updated; stay IDLE, so back-to-back issue is possible.
  - alusel=00: illegal=1 at T+1; no start, no wb_we; stay IDLE.
- WAIT:
  - Counter starts at 0 on entry and increments each cycle.
  - Only the latched unit's done is honoured; done from other units is ignored.
  - Done at cycle N: wb_we=latched rwe at N+1, state IDLE at N+1 (dec_ready=1 at N+1).
  - Minimum multi-cycle latency: done at T+1 gives wb_we at T+2.
  - Counter reaches TIMEOUT-1 with no done: timeout_err=1 (sticky), no write, IDLE next cycle.
  - Done in the same cycle as the timeout wins: normal writeback, no error.
- wb_we is a one-cycle pulse. wb_addr and wb_src hold their values until the next writeback or illegal event.
- Stores never assert wb_we, even if dec_rwe=1.
- Counter width is clog2(TIMEOUT+1). TIMEOUT=0 means it never expires.
- Reset asserted during WAIT aborts the operation; no wb_we is generated after reset release.

Decomposition:
- Shared package exec_sched_pkg:
  - ALUSelect encodings (SEL_NONE/IALU/FALU/CORDIC).
  - wb_src enum (WB_IALU/LSU/FALU/CORDIC).
  - State enum (S_IDLE/S_WAIT).
- One sub-module, sched_timeout_cnt:
  - Ports: clk, rst_n, clear, enable, expired.
  - Parameterised by TIMEOUT.

Test Plan:
- IALU back-to-back: two accepts, alusel=01, rwe=1, rd=3 then 7 -> wb_we pulses at T+1 and T+2, wb_addr=0x03 then 0x07, wb_src=00, dec_ready stays 1.
- FALU op: alusel=10, rd=5, rwe=1; falu_done 4 cycles after accept -> falu_start pulse in T, busy for 4 cycles, wb_we at T+5 with wb_addr=0x25, wb_src=10.
- Load vs store:
  - load rd=9, lsu_done at T+2 -> wb_we at T+3, wb_src=01.
  - store with rwe=1 -> lsu_start pulses, no wb_we, dec_ready high at T+3.
- Wrong-unit done: CORDIC op issued, falu_done pulsed -> ignored, still WAIT; cordic_done next cycle -> wb_src=11.
- Timeout: TIMEOUT=8, FALU issued, no done -> timeout_err=1 eight cycles after WAIT entry, no wb_we, dec_ready=1 next cycle; a later done pulse is ignored.
- Illegal and reset:
  - alusel=00 accepted -> illegal pulse, no start, no wb_we.
  - rst_n low mid-WAIT -> all outputs 0, IDLE; no write after release.
